// File: rtl/dma_write_dst_fsm_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA destination-write stage and memory.
interface dma_write_dst_fsm_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [LEN_W-1:0]      awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/dma_write_dst_fsm.sv
// DMA destination-write stage: drains the read-data FIFO into one AXI4 INCR burst per
// descriptor and pulses wr_fsm_done once the write response has been taken.
module dma_write_dst_fsm #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    input  logic                fifo_not_empty,
    input  logic [DATA_W-1:0]   fifo_rd_data,
    output logic                fifo_rd_en,
    output logic                wr_fsm_done,
    output logic                wr_error,
    dma_write_dst_fsm_if.master axi
);

    localparam logic [2:0] AW_SIZE  = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        ADDR  = 6'b000010,
        DATA  = 6'b000100,
        RESP  = 6'b001000,
        DONE  = 6'b010000,
        REARM = 6'b100000
    } state_t;

    state_t             state;
    logic               awvalid_q;
    logic               bready_q;
    logic [ADDR_W-1:0]  awaddr_q;
    logic [LEN_W-1:0]   awlen_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic               w_valid;
    logic               w_last;
    logic               beat_acc;

    // The FIFO is first-word-fall-through, so its head word drives W directly and a
    // stalled beat stays valid until it is popped.
    assign w_valid  = (state == DATA) && fifo_not_empty;
    assign w_last   = w_valid && (beat_cnt == awlen_q);
    assign beat_acc = w_valid && axi.wready;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = AW_SIZE;
    assign axi.awburst = BURST_INCR;
    assign axi.wvalid  = w_valid;
    assign axi.wdata   = fifo_rd_data;
    assign axi.wstrb   = '1;
    assign axi.wlast   = w_last;
    assign axi.bready  = bready_q;
    assign fifo_rd_en  = beat_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            wr_fsm_done <= 1'b0;
            wr_error    <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            wr_fsm_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        awaddr_q  <= dst_addr;
                        awlen_q   <= length;
                        wr_error  <= 1'b0;
                        beat_cnt  <= '0;
                        awvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    // The final beat leaves beat_cnt at awlen so it can never wrap.
                    if (beat_acc) begin
                        if (w_last) begin
                            bready_q <= 1'b1;
                            state    <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (axi.bvalid) begin
                        wr_error    <= (axi.bresp != RESP_OKAY);
                        bready_q    <= 1'b0;
                        wr_fsm_done <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= REARM;
                end
                REARM: begin
                    // go is a level held until the descriptor ack lands; wait it out.
                    if (!go) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_dst_fsm.sv
// Randomized bench for dma_write_dst_fsm: a FIFO model and AXI slave feed the block while
// a transaction-level model of the expected burst checks every handshake.
module tb_dma_write_dst_fsm;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 8;

    logic                clk;
    logic                reset_n;
    logic                go;
    logic [ADDR_W-1:0]   dst_addr;
    logic [LEN_W-1:0]    length;
    logic                fifo_not_empty;
    logic [DATA_W-1:0]   fifo_rd_data;
    logic                fifo_rd_en;
    logic                wr_fsm_done;
    logic                wr_error;

    dma_write_dst_fsm_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) axi ();

    dma_write_dst_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .go             (go),
        .dst_addr       (dst_addr),
        .length         (length),
        .fifo_not_empty (fifo_not_empty),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_en     (fifo_rd_en),
        .wr_fsm_done    (wr_fsm_done),
        .wr_error       (wr_error),
        .axi            (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] src[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive_fifo();
        fifo_not_empty = (fq.size() != 0);
        fifo_rd_data   = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One descriptor end to end. The model: exactly one AW with the descriptor fields, the
    // first len+1 FIFO words written in order, wlast on the last, B after all beats, one
    // done pulse, and wr_error equal to whether the response was an error.
    task automatic run_desc(input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] resp,
                            input int prefill, input int extra, input int push_pct,
                            input int aw_pct, input int aw_hold, input int w_pct, input int go_hold);
        int beat, done_cnt, aw_cnt, pushed, since_done;
        logic aw_done, b_done, b_pend, aw_stall, w_stall;
        logic [DATA_W-1:0] w_prev;
        logic [ADDR_W-1:0] a_prev;
        logic [DATA_W-1:0] w;
        src.delete(); exp_q.delete(); fq.delete();
        for (int i = 0; i < len + 1 + extra; i++) begin
            w = rand_word();
            src.push_back(w);
            if (i <= len) exp_q.push_back(w);
        end
        pushed = 0;
        for (int i = 0; i < prefill; i++) begin
            if (src.size() > 0) begin
                fq.push_back(src.pop_front());
                pushed++;
            end
        end
        beat = 0; done_cnt = 0; aw_cnt = 0; since_done = -1;
        aw_done = 1'b0; b_done = 1'b0; b_pend = 1'b0; aw_stall = 1'b0; w_stall = 1'b0;
        w_prev = '0; a_prev = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (src.size() > 0 && $urandom_range(99) < push_pct) begin
                fq.push_back(src.pop_front());
                pushed++;
            end
            drive_fifo();
            dst_addr    = addr;
            length      = LEN_W'(len);
            axi.awready = (cyc >= aw_hold) && ($urandom_range(99) < aw_pct);
            axi.wready  = ($urandom_range(99) < w_pct);
            if (beat == len + 1 && !b_done && !b_pend && $urandom_range(1) == 1) b_pend = 1'b1;
            axi.bvalid  = b_pend;
            axi.bresp   = resp;
            go          = (since_done < 0) || (since_done < go_hold);
            #1;
            if (aw_stall) begin
                check_eq("aw_valid_held", axi.awvalid, 1'b1);
                check_eq("aw_addr_held", axi.awaddr, a_prev);
            end
            if (w_stall) begin
                check_eq("w_valid_held", axi.wvalid, 1'b1);
                check_eq("w_data_held", axi.wdata, w_prev);
            end
            check_eq("rd_en_eq_beat", fifo_rd_en, axi.wvalid && axi.wready);
            if (!aw_done) check_eq("no_w_before_aw", axi.wvalid, 1'b0);
            if (fq.size() == 0) check_eq("no_w_when_empty", axi.wvalid, 1'b0);
            if (!aw_done && cyc > 0) check_eq("err_cleared_at_go", wr_error, 1'b0);
            if (axi.awvalid && axi.awready) begin
                aw_cnt++;
                aw_done = 1'b1;
                check_eq("awaddr", axi.awaddr, addr);
                check_eq("awlen", axi.awlen, LEN_W'(len));
                check_eq("awsize", axi.awsize, 3'd6);
                check_eq("awburst", axi.awburst, 2'b01);
                check_eq("wstrb", axi.wstrb, {(DATA_W/8){1'b1}});
            end
            if (axi.wvalid && axi.wready) begin
                if (beat <= len) begin
                    check_eq("wdata", axi.wdata, exp_q[beat]);
                    check_eq("wlast", axi.wlast, beat == len);
                end else begin
                    check_eq("extra_beat", beat, len);
                end
                if (fq.size() > 0) void'(fq.pop_front());
                beat++;
            end
            if (axi.bvalid && axi.bready) begin
                b_done = 1'b1;
                b_pend = 1'b0;
            end
            if (wr_fsm_done) begin
                done_cnt++;
                check_eq("done_after_b", b_done, 1'b1);
                check_eq("single_done", done_cnt, 1);
                since_done = 0;
            end else if (since_done >= 0) begin
                since_done++;
                check_eq("no_retrigger", axi.awvalid, 1'b0);
            end
            aw_stall = axi.awvalid && !axi.awready;
            a_prev   = axi.awaddr;
            w_stall  = axi.wvalid && !axi.wready;
            w_prev   = axi.wdata;
            if (since_done >= go_hold + 3) break;
        end
        go = 1'b0;
        check_eq("done_seen", done_cnt, 1);
        check_eq("aw_count", aw_cnt, 1);
        check_eq("beat_total", beat, len + 1);
        check_eq("wr_error", wr_error, resp != 2'b00);
        check_eq("fifo_leftover", fq.size(), pushed - (len + 1));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0; go = 1'b0; dst_addr = '0; length = '0;
        fifo_not_empty = 1'b0; fifo_rd_data = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_awvalid", axi.awvalid, 1'b0);
        check_eq("rst_wvalid", axi.wvalid, 1'b0);
        check_eq("rst_wlast", axi.wlast, 1'b0);
        check_eq("rst_bready", axi.bready, 1'b0);
        check_eq("rst_rd_en", fifo_rd_en, 1'b0);
        check_eq("rst_done", wr_fsm_done, 1'b0);
        check_eq("rst_error", wr_error, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        run_desc(64'h1000, 0, 2'b00, 1, 0, 100, 100, 0, 100, 0);
        run_desc({$urandom, $urandom}, 3, 2'b00, 4, 0, 100, 100, 0, 45, 0);
        run_desc({$urandom, $urandom}, 7, 2'b00, 0, 0, 33, 100, 0, 100, 0);
        run_desc({$urandom, $urandom}, 5, 2'b00, 6, 2, 100, 100, 10, 100, 0);
        run_desc({$urandom, $urandom}, 2, 2'b10, 3, 1, 100, 100, 0, 100, 0);
        run_desc({$urandom, $urandom}, 1, 2'b00, 2, 0, 100, 100, 0, 100, 5);
        for (int d = 0; d < 24; d++) begin
            int len;
            len = $urandom_range(15);
            run_desc({$urandom, $urandom}, len, 2'($urandom_range(3)),
                     $urandom_range(len + 1), $urandom_range(3), $urandom_range(100, 30),
                     $urandom_range(100, 20), $urandom_range(5), $urandom_range(100, 20),
                     $urandom_range(4));
        end

        // Reset in the middle of a 4-beat burst after two beats have gone out.
        begin
            int beat;
            fq.delete();
            for (int i = 0; i < 4; i++) fq.push_back(rand_word());
            beat = 0;
            for (int cyc = 0; cyc < 50 && beat < 2; cyc++) begin
                @(negedge clk);
                drive_fifo();
                dst_addr = 64'h2000; length = LEN_W'(3); go = 1'b1;
                axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
                #1;
                if (axi.wvalid && axi.wready) begin
                    void'(fq.pop_front());
                    beat++;
                end
            end
            check_eq("mid_rst_beats", beat, 2);
            @(negedge clk);
            drive_fifo();
            reset_n = 1'b0; go = 1'b0;
            @(posedge clk);
            #1;
            check_eq("mid_rst_awvalid", axi.awvalid, 1'b0);
            check_eq("mid_rst_wvalid", axi.wvalid, 1'b0);
            check_eq("mid_rst_wlast", axi.wlast, 1'b0);
            check_eq("mid_rst_bready", axi.bready, 1'b0);
            check_eq("mid_rst_rd_en", fifo_rd_en, 1'b0);
            check_eq("mid_rst_done", wr_fsm_done, 1'b0);
            check_eq("mid_rst_error", wr_error, 1'b0);
            @(negedge clk);
            reset_n = 1'b1;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clk);
                axi.bvalid = 1'b1;
                #1;
                check_eq("post_rst_done", wr_fsm_done, 1'b0);
                check_eq("post_rst_awvalid", axi.awvalid, 1'b0);
                check_eq("post_rst_rd_en", fifo_rd_en, 1'b0);
            end
            axi.bvalid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_write_dst_fsm.md
Name: dma_write_dst_fsm

Overview:
Destination-write stage of the DMA data path. Drains the read-data FIFO filled by the source-read stage and writes it to destination memory as one AXI4 INCR burst per descriptor. Completes when the B response arrives, then pulses wr_fsm_done so the source-read stage acknowledges the descriptor.

Parameters:
DATA_W, 512, data beat width in bits; power of two, 8..1024
ADDR_W, 64, AXI address width
LEN_W, 8, burst length field width (AXI len encoding: beats-1)

Ports:
clk  input  1  clock
reset_n  input  1  reset: synchronous, active-low
go  input  1  descriptor control.go; level, held high until descriptor is acked
dst_addr  input  ADDR_W  descriptor destination byte address
length  input  LEN_W  descriptor length, beats-1
fifo_not_empty  input  1  read-data FIFO has a word; first-word-fall-through
fifo_rd_data  input  DATA_W  FIFO head word, valid when fifo_not_empty
fifo_rd_en  output  1  pop FIFO head this cycle
awvalid / awready  output / input  1  AW handshake
awaddr  output  ADDR_W  burst address
awlen  output  LEN_W  burst length
awsize  output  3  log2(DATA_W/8)
awburst  output  2  2'b01 (INCR)
wvalid / wready  output / input  1  W handshake
wdata  output  DATA_W  write beat
wstrb  output  DATA_W/8  all ones
wlast  output  1  final beat of burst
bvalid / bready  input / output  1  B handshake
bresp  input  2  write response
wr_fsm_done  output  1  one-cycle pulse on burst completion
wr_error  output  1  sticky: last burst returned bresp != OKAY

Behaviour:
- Reset values: state IDLE; awvalid, wvalid, wlast, bready, fifo_rd_en, wr_fsm_done, wr_error = 0; beat counter = 0. Reset mid-burst abandons the burst with no further handshakes and no done pulse.
- One-hot FSM: IDLE, ADDR, DATA, RESP, DONE, REARM.
- IDLE: when go=1, latch dst_addr and length into awaddr/awlen, clear wr_error, clear beat counter, set awvalid=1 (registered), go to ADDR.
- ADDR: hold awvalid and AW fields stable until awready. On the awvalid&awready cycle, awvalid<=0, go to DATA. No W beat is driven before the AW handshake.
- DATA: wvalid = fifo_not_empty (combinational). wdata = fifo_rd_data. fifo_rd_en = wvalid & wready. wlast = wvalid & (beat_cnt == awlen). Each accepted beat increments beat_cnt. FIFO empty inserts idle cycles with wvalid=0; wready low holds the beat with no pop. An accepted beat with wlast sends the FSM to RESP.
- RESP: bready=1 (registered, asserted on entry). On bvalid: wr_error <= (bresp != 2'b00); bready<=0; go to DONE.
- DONE: wr_fsm_done=1 for exactly this cycle; go to REARM.
- REARM: wait for go=0 and then return to IDLE. This prevents a retrigger on a go level that is still held before the descriptor ack takes effect.
- beat_cnt width is LEN_W. Its maximum value equals awlen, so it never wraps. length=0 produces a single beat with wlast=1.
- Throughput: one beat per cycle when the FIFO is non-empty and wready=1.
- fifo_rd_en is never asserted outside DATA. Extra FIFO words beyond awlen+1 are left in place.
- AXI stability: wvalid never drops while wready=0 within a burst, because a FIFO word stays present until popped.

Test Plan:
- Single beat: go=1, dst_addr=0x1000, length=0, FIFO holds 1 word, awready/wready/bvalid immediate -> awaddr=0x1000, awlen=0, awsize=6, one W beat with wlast=1, wr_fsm_done one pulse, fifo_rd_en asserted once.
- 4-beat burst with backpressure: length=3, wready toggling 1,0,0,1,... -> exactly 4 pops, wdata order matches FIFO order, wlast only on the 4th beat, data stable while wready=0.
- FIFO underflow gaps: length=7, FIFO refilled 1 word every 3 cycles -> wvalid low during empty cycles, 8 beats total, no pop while empty, done after the B response.
- AW delay: awready held low for 10 cycles with FIFO full -> no wvalid before the AW handshake, AW fields stable throughout.
- Error response: bresp=2'b10 -> wr_error=1 after done. The next descriptor with OKAY clears it at go.
- go held high for 5 cycles after done -> no second AW issued until go returns to 0. Reset asserted mid-DATA after 2 of 4 beats -> all outputs 0 next cycle, FSM in IDLE, no done pulse.
